// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM states and latency helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mul_state_t;

    // Number of RUN cycles needed to retire every multiplier bit.
    function automatic int cycles(input int size, input int bits_per_cycle);
        return size / bits_per_cycle;
    endfunction

    // Edges from the start-sampling edge to done for the default 32-bit,
    // radix-2 configuration; the stall logic holds the instruction this long.
    localparam int MultiplyLatency = cycles(32, 1) + 1;

endpackage

// File: rtl/mul_step.sv
// One shift-add step: acc_next = acc + (digit * mcand) << shift.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   acc      running accumulator (AccW bits)
//   mcand    unsigned multiplicand magnitude
//   digit    low BitsPerCycle bits of the remaining multiplier
//   shift    bit weight of this digit
//   acc_next accumulator after adding the shifted partial product
module mul_step #(
    parameter int Size         = 32,
    parameter int BitsPerCycle = 1,
    parameter int AccW         = 2 * Size + BitsPerCycle,
    parameter int ShW          = $clog2(Size)
) (
    input  logic [AccW-1:0]         acc,
    input  logic [Size-1:0]         mcand,
    input  logic [BitsPerCycle-1:0] digit,
    input  logic [ShW-1:0]          shift,
    output logic [AccW-1:0]         acc_next
);

    // Both factors are zero-extended to the product width so the multiply
    // keeps every bit of the partial product.
    logic [Size+BitsPerCycle-1:0] partial;

    assign partial  = {{BitsPerCycle{1'b0}}, mcand} * {{Size{1'b0}}, digit};
    assign acc_next = acc + ({{(AccW-Size-BitsPerCycle){1'b0}}, partial} << shift);

endmodule

// File: rtl/sequential_multiplier.sv
// Iterative shift-add multiplier, signed or unsigned, full double-width product.
// Latency: Size/BitsPerCycle + 1 edges from the start-sampling edge to done.
// Backpressure: start is only honoured in IDLE; busy tells the pipeline to stall.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   start, signed_op, a, b  request; sampled together in IDLE
//   busy                    high in RUN and FIX
//   done                    one-cycle pulse when product_hi/product_lo update
//   product_hi, product_lo  upper and lower halves of the 2*Size product
module sequential_multiplier
    import mul_pkg::*;
#(
    parameter int Size         = 32,
    parameter int BitsPerCycle = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            signed_op,
    input  logic [Size-1:0] a,
    input  logic [Size-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [Size-1:0] product_lo,
    output logic [Size-1:0] product_hi
);

    // BitsPerCycle is expected to be 1, 2 or 4 and to divide Size evenly.
    localparam int Steps  = cycles(Size, BitsPerCycle);
    localparam int CountW = $clog2(Steps + 1);
    localparam int ShW    = $clog2(Size);
    // Headroom of BitsPerCycle bits so no partial sum can wrap before truncation.
    localparam int AccW   = 2 * Size + BitsPerCycle;

    mul_state_t        state, state_next;
    logic [Size-1:0]   mcand;
    logic [Size-1:0]   mplier;
    logic              neg;
    logic [AccW-1:0]   acc;
    logic [AccW-1:0]   acc_next;
    logic [CountW-1:0] count;
    logic [ShW-1:0]    shift;

    logic [Size-1:0]   a_mag;
    logic [Size-1:0]   b_mag;
    logic [AccW-1:0]   acc_fixed;
    logic [AccW-1:0]   acc_fixed_unused;

    // Magnitudes are Size-bit unsigned, so the most negative value maps to
    // 2^(Size-1) without overflow.
    assign a_mag = (signed_op && a[Size-1]) ? -a : a;
    assign b_mag = (signed_op && b[Size-1]) ? -b : b;

    // Sign restore; bits above 2*Size are discarded (result is modulo 2^(2*Size)).
    assign acc_fixed        = neg ? -acc : acc;
    assign acc_fixed_unused = acc_fixed;

    mul_step #(
        .Size         (Size),
        .BitsPerCycle (BitsPerCycle),
        .AccW         (AccW),
        .ShW          (ShW)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .digit    (mplier[BitsPerCycle-1:0]),
        .shift    (shift),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (count == CountW'(1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX);

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand      <= '0;
            mplier     <= '0;
            neg        <= 1'b0;
            acc        <= '0;
            count      <= '0;
            shift      <= '0;
            done       <= 1'b0;
            product_lo <= '0;
            product_hi <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= signed_op & (a[Size-1] ^ b[Size-1]);
                        acc    <= '0;
                        shift  <= '0;
                        count  <= CountW'(Steps);
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> BitsPerCycle;
                    shift  <= shift + ShW'(BitsPerCycle);
                    count  <= count - CountW'(1);
                end
                FIX: begin
                    product_hi <= acc_fixed[2*Size-1:Size];
                    product_lo <= acc_fixed[Size-1:0];
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed bench for the sequential multiplier at BitsPerCycle 1 and 4.
// Latency: n/a.
// Backpressure: n/a.
module tb_sequential_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start4;
    logic        signed_op;
    logic [31:0] a, b;
    logic        busy1, done1, busy4, done4;
    logic [31:0] lo1, hi1, lo4, hi4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sequential_multiplier #(.Size(32), .BitsPerCycle(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
        .signed_op  (signed_op),
        .a          (a),
        .b          (b),
        .busy       (busy1),
        .done       (done1),
        .product_lo (lo1),
        .product_hi (hi1)
    );

    sequential_multiplier #(.Size(32), .BitsPerCycle(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .start      (start4),
        .signed_op  (signed_op),
        .a          (a),
        .b          (b),
        .busy       (busy4),
        .done       (done4),
        .product_lo (lo4),
        .product_hi (hi4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start4 = v;
        else          start1 = v;
    endtask

    task automatic peek(input int sel, output logic bz, output logic dn, output logic [63:0] p);
        if (sel != 0) begin bz = busy4; dn = done4; p = {hi4, lo4}; end
        else          begin bz = busy1; dn = done1; p = {hi1, lo1}; end
    endtask

    function automatic string tg(input string t, input int sel);
        return $sformatf("%s/r%0d", t, (sel != 0) ? 4 : 1);
    endfunction

    // Present operands at a falling edge; they are sampled on the next rising
    // edge. Operands are then scrambled to show the result ignores them.
    task automatic start_op(input int sel, input logic [31:0] av, input logic [31:0] bv, input logic s);
        a = av; b = bv; signed_op = s;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; signed_op = ~s;
    endtask

    // Waits for done, checking latency, busy length, busy/done exclusivity and
    // the product. If poke_at >= 0, pulses start with 9 x 9 at that cycle.
    // Returns at the falling edge where done is high.
    task automatic wait_done(input int sel, input string tag, input logic [63:0] exp, input int poke_at);
        int   cyc = 0, nbusy = 0, both = 0;
        int   lat = (sel != 0) ? 9 : 33;
        logic bz, dn;
        logic [63:0] p;
        peek(sel, bz, dn, p);
        while (!dn && cyc < 60) begin
            if (bz) nbusy++;
            if (cyc == poke_at) begin
                a = 32'd9; b = 32'd9; signed_op = 1'b0;
                set_start(sel, 1'b1);
            end else begin
                set_start(sel, 1'b0);
            end
            @(negedge clk);
            cyc++;
            peek(sel, bz, dn, p);
            if (bz && dn) both++;
        end
        set_start(sel, 1'b0);
        chk(tg({tag, " latency"}, sel), 64'(cyc), 64'(lat));
        chk(tg({tag, " busy_cycles"}, sel), 64'(nbusy), 64'(lat));
        chk(tg({tag, " busy_and_done"}, sel), 64'(both), 64'd0);
        chk(tg({tag, " product"}, sel), p, exp);
    endtask

    // One cycle after done: done gone, idle, product held.
    task automatic check_idle(input int sel, input string tag, input logic [63:0] exp);
        logic bz, dn;
        logic [63:0] p;
        @(negedge clk);
        peek(sel, bz, dn, p);
        chk(tg({tag, " done_pulse_len"}, sel), {63'd0, dn}, 64'd0);
        chk(tg({tag, " idle_busy"}, sel), {63'd0, bz}, 64'd0);
        repeat (3) @(negedge clk);
        peek(sel, bz, dn, p);
        chk(tg({tag, " held"}, sel), p, exp);
    endtask

    initial begin
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
        signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        // Start is asserted during reset; reset must win.
        start1 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        chk("reset busy1", {63'd0, busy1}, 64'd0);
        chk("reset done1", {63'd0, done1}, 64'd0);
        chk("reset prod1", {hi1, lo1}, 64'd0);
        chk("reset busy4", {63'd0, busy4}, 64'd0);
        chk("reset done4", {63'd0, done4}, 64'd0);
        chk("reset prod4", {hi4, lo4}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset busy1", {63'd0, busy1}, 64'd0);

        for (int sel = 0; sel < 2; sel++) begin
            start_op(sel, 32'd7, 32'd6, 1'b0);
            wait_done(sel, "u7x6", 64'd42, -1);
            check_idle(sel, "u7x6", 64'd42);

            start_op(sel, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
            wait_done(sel, "umax", 64'hFFFF_FFFE_0000_0001, -1);
            check_idle(sel, "umax", 64'hFFFF_FFFE_0000_0001);

            start_op(sel, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
            wait_done(sel, "smin_x_m1", 64'h0000_0000_8000_0000, -1);
            check_idle(sel, "smin_x_m1", 64'h0000_0000_8000_0000);

            start_op(sel, 32'hFFFF_FFFD, 32'd5, 1'b1);
            wait_done(sel, "s_m3x5", 64'hFFFF_FFFF_FFFF_FFF1, -1);
            check_idle(sel, "s_m3x5", 64'hFFFF_FFFF_FFFF_FFF1);

            start_op(sel, 32'hFFFF_FFFD, 32'd5, 1'b0);
            wait_done(sel, "u_fffd_x5", 64'h0000_0004_FFFF_FFF1, -1);
            check_idle(sel, "u_fffd_x5", 64'h0000_0004_FFFF_FFF1);

            // Start while busy is ignored; start in the done cycle is accepted.
            start_op(sel, 32'd3, 32'd4, 1'b0);
            wait_done(sel, "busy_start", 64'd12, (sel != 0) ? 5 : 10);
            start_op(sel, 32'd9, 32'd9, 1'b0);
            wait_done(sel, "back2back", 64'd81, -1);
            check_idle(sel, "back2back", 64'd81);

            // Reset mid-operation aborts with no done pulse.
            begin
                int ndone = 0;
                logic bz, dn;
                logic [63:0] p;
                start_op(sel, 32'd100, 32'd100, 1'b0);
                repeat ((sel != 0) ? 4 : 14) @(negedge clk);
                peek(sel, bz, dn, p);
                chk(tg("abort still_busy", sel), {63'd0, bz}, 64'd1);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                peek(sel, bz, dn, p);
                chk(tg("abort busy", sel), {63'd0, bz}, 64'd0);
                chk(tg("abort done", sel), {63'd0, dn}, 64'd0);
                chk(tg("abort prod", sel), p, 64'd0);
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    peek(sel, bz, dn, p);
                    if (dn) ndone++;
                end
                chk(tg("abort no_done", sel), 64'(ndone), 64'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sequential_multiplier.md
Name: sequential_multiplier

Overview:
- Iterative shift-add integer multiplier; the arithmetic counterpart to the pipelined divide unit in the execute stage.
- Trades latency for area: it processes BitsPerCycle multiplier bits per clock and returns the full double-width product.
- A start/busy/done handshake lets the pipeline stall control hold the instruction until done.
- Supports unsigned and two's-complement signed operands.

Parameters:
- Size, 32, operand width in bits; the product is 2*Size bits.
- BitsPerCycle, 1, multiplier bits retired per RUN cycle. Legal values are 1, 2 and 4, and Size must be divisible by BitsPerCycle.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- signed_op  input  1  1 = treat a and b as two's complement; 0 = unsigned. Sampled with start.
- a  input  Size  multiplicand, sampled with start.
- b  input  Size  multiplier, sampled with start.
- busy  output  1  high while an operation is in flight (RUN or FIX).
- done  output  1  one-cycle pulse when product_hi/product_lo become valid.
- product_lo  output  Size  low half of the product.
- product_hi  output  Size  high half of the product.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - busy = 0, done = 0, product_lo = 0, product_hi = 0.
  - The internal accumulator, operand registers and counter are cleared.
- Reset overrides start on the same edge.
- Reset mid-operation aborts the operation: no done pulse, and the outputs go to 0.
- States: IDLE, RUN, FIX.
  - IDLE, start=1:
    - Latch mcand = |a| and mplier = |b|. Absolute value is applied only if signed_op=1; the magnitude is Size bits unsigned, so -2^(Size-1) maps to 2^(Size-1).
    - Latch neg = signed_op & (a[Size-1] ^ b[Size-1]).
    - Clear the 2*Size accumulator, set count = Size/BitsPerCycle, go to RUN.
  - IDLE, start=0: remain in IDLE; the outputs hold the last result.
  - RUN, each edge:
    - acc += (mplier[BitsPerCycle-1:0] * mcand) << shift.
    - mplier >>= BitsPerCycle, shift += BitsPerCycle, count -= 1.
    - When count reaches 1 on this edge, go to FIX.
  - FIX, one edge:
    - {product_hi, product_lo} = neg ? -acc : acc, computed modulo 2^(2*Size).
    - done = 1 for the following cycle only.
    - Go to IDLE.
- Latency is fixed at Size/BitsPerCycle + 1 edges from the start-sampling edge to done (33 for the defaults).
  - There is no early termination for zero or small operands.
  - Define MultiplyLatency = Size/BitsPerCycle + 1 for the stall logic.
- busy = 1 exactly in RUN and FIX. done and busy are never high together.
- start while busy is ignored; the operation in flight is not disturbed.
- start in the cycle where done=1 is legal: the state is IDLE, so the new operation is accepted back-to-back.
- Operands may change after the start-sampling edge without affecting the result.
- Product registers change only on the FIX edge or on reset; they are stable between operations.
- The accumulator is at least 2*Size + BitsPerCycle bits wide, so no partial sum overflows before truncation to 2*Size.

Decomposition:
- Shared package mul_pkg holds:
  - the state enum (IDLE, RUN, FIX);
  - localparam function cycles(Size, BitsPerCycle);
  - the MultiplyLatency constant used by hazard/stall control, alongside the existing divide latency.
- Natural sub-module: mul_step. It is combinational and computes acc_next from acc, mcand, the low BitsPerCycle bits of mplier and shift, so the radix change stays isolated from the FSM.

Test Plan:
- Reset, then unsigned 7 × 6 -> busy=1 for 33 cycles; done pulses exactly once; product_lo = 42, product_hi = 0.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF -> product_hi = 0xFFFFFFFE, product_lo = 0x00000001.
- Signed 0x80000000 × 0xFFFFFFFF (i.e. -2^31 × -1) -> product_hi = 0x00000000, product_lo = 0x80000000.
- Signed -3 × 5, i.e. 0xFFFFFFFD × 0x00000005 -> product_hi = 0xFFFFFFFF, product_lo = 0xFFFFFFF1. The same operands with signed_op=0 -> product_hi = 0x00000004, product_lo = 0xFFFFFFF1.
- Start 3 × 4, pulse start with 9 × 9 at cycle 10 -> the second start is ignored and the result is 12. Then assert start for 9 × 9 in the done cycle -> accepted back-to-back; 33 cycles later the result is 81.
- Start 100 × 100, assert reset at cycle 15 -> next cycle busy = 0, done = 0, products = 0, and no done pulse follows. Repeat the checks with BitsPerCycle = 4, which must give latency 9.
